// File: rtl/pong_io_pkg.sv
// Shared definitions for the port-B mailbox master: mailbox word offsets,
// FSM state encoding and the input-word packing helper.
package pong_io_pkg;

    localparam logic [15:0] OFF_INPUT    = 16'd0;
    localparam logic [15:0] OFF_BALL_X   = 16'd1;
    localparam logic [15:0] OFF_BALL_Y   = 16'd2;
    localparam logic [15:0] OFF_PADDLE_L = 16'd3;
    localparam logic [15:0] OFF_PADDLE_R = 16'd4;
    localparam logic [15:0] OFF_SCORE    = 16'd5;
    localparam int          N_DISP       = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    function automatic logic [15:0] pack_input(input logic [11:0] cnt, input logic [3:0] btn);
        return {cnt, btn};
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous inputs, cleared by reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw input through the metastability chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/bram_port_b_io.sv
// Port-B master of the CPU mailbox: writes buttons/frame count once per frame,
// burst-reads the five display words and commits them atomically to shadows.
module bram_port_b_io
    import pong_io_pkg::*;
#(
    parameter logic [15:0] MBOX_BASE   = 16'hFF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [3:0]  buttons,
    output logic [15:0] addr_b,
    output logic [15:0] data_b,
    output logic        we_b,
    input  logic [15:0] q_b,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic [15:0] paddle_l,
    output logic [15:0] paddle_r,
    output logic [15:0] score,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    logic [3:0]  btn_s;
    state_t      state_r;
    state_t      state_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_s;
    logic        accept_s;
    logic        cap_valid_r;
    logic [2:0]  cap_idx_r;
    logic [11:0] frame_cnt_r;
    logic [15:0] stage_r [N_DISP];
    logic [15:0] addr_s;
    logic [15:0] data_s;
    logic        we_s;

    for (genvar i = 0; i < 4; i++) begin : g_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (buttons[i]),
            .q     (btn_s[i])
        );
    end

    // Next-state decode; port-B outputs are derived from the upcoming state so they register in step with it.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_s  = ST_WRITE;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_s = ST_READ;
                idx_s   = 3'd0;
            end
            ST_READ: begin
                if (idx_r == 3'd4) begin
                    state_s = ST_DRAIN;
                end else begin
                    idx_s = idx_r + 3'd1;
                end
            end
            ST_DRAIN:  state_s = ST_COMMIT;
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase

        addr_s = addr_b;
        data_s = data_b;
        we_s   = 1'b0;
        if (state_s == ST_WRITE) begin
            addr_s = MBOX_BASE + OFF_INPUT;
            data_s = pack_input(frame_cnt_r, btn_s);
            we_s   = 1'b1;
        end else if (state_s == ST_READ) begin
            addr_s = MBOX_BASE + OFF_BALL_X + {13'd0, idx_s};
        end else begin
            addr_s = addr_b;
        end
    end

    // FSM state, burst index, frame counter, overrun flag and registered port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 3'd0;
            cap_valid_r <= 1'b0;
            cap_idx_r   <= 3'd0;
            frame_cnt_r <= 12'd0;
            overrun     <= 1'b0;
            addr_b      <= 16'd0;
            data_b      <= 16'd0;
            we_b        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            // read data returns one cycle after the address, so capture trails issue by one
            cap_valid_r <= (state_r == ST_READ);
            cap_idx_r   <= idx_r;
            addr_b      <= addr_s;
            data_b      <= data_s;
            we_b        <= we_s;
            busy        <= (state_s != ST_IDLE);
            frame_done  <= (state_s == ST_COMMIT);
            if (accept_s) begin
                frame_cnt_r <= frame_cnt_r + 12'd1;
            end
            if (frame_start && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Staging registers collect the burst without disturbing the visible shadows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_DISP; k++) begin
                stage_r[k] <= 16'd0;
            end
        end else if (cap_valid_r) begin
            stage_r[cap_idx_r] <= q_b;
        end
    end

    // All shadows load together on the commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_x   <= 16'd0;
            ball_y   <= 16'd0;
            paddle_l <= 16'd0;
            paddle_r <= 16'd0;
            score    <= 16'd0;
        end else if (state_r == ST_COMMIT) begin
            ball_x   <= stage_r[0];
            ball_y   <= stage_r[1];
            paddle_l <= stage_r[2];
            paddle_r <= stage_r[3];
            score    <= stage_r[4];
        end
    end

endmodule
